// File: rtl/wb_regfile_reader.sv
// wb_regfile_reader: writeback-to-decode register bank with a pending-write
// scoreboard and two registered read ports (one-cycle latency, rd_valid).
// Optional feature macro: WB_BYPASS_EN
//   defined   -> same-cycle WB write is forwarded to an accepted read, and a
//                register whose last pending write lands this cycle is not busy.
//   undefined -> reads see the old value; busy is simply pend[r] != 0.
module wb_regfile_reader #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned PEND_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wb_reg_write,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              id_req,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic              id_mark,
    input  logic [ADDR_W-1:0] id_rd,
    output logic              id_stall,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rd_valid
);

    localparam int unsigned       NREG     = 2**ADDR_W;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [DATA_W-1:0] regs      [NREG];
    logic [PEND_W-1:0] pend      [NREG];
    logic [PEND_W-1:0] pend_next [NREG];

    logic              wr_en;
    logic              busy_rs1;
    logic              busy_rs2;
    logic              mark_sat;
    logic              accept;
    logic              mark_ok;
    logic [DATA_W-1:0] rd1_val;
    logic [DATA_W-1:0] rd2_val;

    // x0 is never written, so regs[0] stays at its reset value of zero
    assign wr_en = wb_reg_write && (wb_rd != '0);

    // Scoreboard busy check for both source operands
    always_comb begin
        busy_rs1 = (id_rs1 != '0) && (pend[id_rs1] != '0);
        busy_rs2 = (id_rs2 != '0) && (pend[id_rs2] != '0);
`ifdef WB_BYPASS_EN
        if (wr_en && (wb_rd == id_rs1) && (pend[id_rs1] == PEND_ONE)) busy_rs1 = 1'b0;
        if (wr_en && (wb_rd == id_rs2) && (pend[id_rs2] == PEND_ONE)) busy_rs2 = 1'b0;
`endif
    end

    // A mark into a saturated counter must wait, it cannot be recorded
    assign mark_sat = id_mark && (id_rd != '0) && (pend[id_rd] == PEND_MAX);
    assign id_stall = id_req && (busy_rs1 || busy_rs2 || mark_sat);
    assign accept   = id_req && !id_stall;
    assign mark_ok  = accept && id_mark && (id_rd != '0);

    // Operand selection, optionally forwarding the WB write in flight
    always_comb begin
        rd1_val = regs[id_rs1];
        rd2_val = regs[id_rs2];
`ifdef WB_BYPASS_EN
        if (wr_en && (wb_rd == id_rs1)) rd1_val = wb_data;
        if (wr_en && (wb_rd == id_rs2)) rd2_val = wb_data;
`endif
    end

    // Pending-counter update: mark increments, WB write decrements (no
    // underflow); a mark and a write to the same index leave it unchanged
    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            pend_next[i] = pend[i];
            if (mark_ok && (id_rd == ADDR_W'(i)) &&
                !(wr_en && (wb_rd == ADDR_W'(i)))) begin
                pend_next[i] = pend[i] + PEND_ONE;
            end else if (wr_en && (wb_rd == ADDR_W'(i)) &&
                         !(mark_ok && (id_rd == ADDR_W'(i))) &&
                         (pend[i] != '0)) begin
                pend_next[i] = pend[i] - PEND_ONE;
            end
        end
    end

    // Register bank, scoreboard and read-port state
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
                pend[i] <= '0;
            end
            rs1_data <= '0;
            rs2_data <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_en) regs[wb_rd] <= wb_data;
            for (int unsigned i = 0; i < NREG; i++) begin
                pend[i] <= pend_next[i];
            end
            rd_valid <= accept;
            if (accept) begin
                rs1_data <= rd1_val;
                rs2_data <= rd2_val;
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile_reader.sv
// Directed bench for wb_regfile_reader: a vector table for the basic read,
// write, x0 and scoreboard behaviour, plus hand-written multi-cycle sequences.
module tb_wb_regfile_reader;

    logic        clock;
    logic        reset;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        id_req;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_mark;
    logic [4:0]  id_rd;
    logic        id_stall;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rd_valid;

    int total = 0;
    int bad   = 0;

    wb_regfile_reader #(
        .DATA_W(32),
        .ADDR_W(5),
        .PEND_W(2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .wb_reg_write(wb_reg_write),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .id_req      (id_req),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_mark     (id_mark),
        .id_rd       (id_rd),
        .id_stall    (id_stall),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .rd_valid    (rd_valid)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        we;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic        req;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        mark;
        logic [4:0]  mrd;
        logic        stall;
        logic        valid;
        logic [31:0] d1;
        logic [31:0] d2;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [4:0] wrd, input logic [31:0] wdata,
                                input logic req, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic mark, input logic [4:0] mrd,
                                input logic stall, input logic valid,
                                input logic [31:0] d1, input logic [31:0] d2);
        vec_t v;
        v.we = we; v.wrd = wrd; v.wdata = wdata;
        v.req = req; v.rs1 = rs1; v.rs2 = rs2;
        v.mark = mark; v.mrd = mrd;
        v.stall = stall; v.valid = valid; v.d1 = d1; v.d2 = d2;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic we, input logic [4:0] wrd, input logic [31:0] wdata,
                          input logic req, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic mark, input logic [4:0] mrd);
        wb_reg_write = we; wb_rd = wrd; wb_data = wdata;
        id_req = req; id_rs1 = rs1; id_rs2 = rs2;
        id_mark = mark; id_rd = mrd;
    endtask

    // Inputs are already driven; check the combinational stall, clock once,
    // then check the registered read port
    task automatic cyc(input string nm, input logic es, input logic ev,
                       input logic [31:0] e1, input logic [31:0] e2);
        #1;
        check({nm, ".stall"}, {31'b0, id_stall}, {31'b0, es});
        @(posedge clock);
        #1;
        check({nm, ".valid"}, {31'b0, rd_valid}, {31'b0, ev});
        if (ev) begin
            check({nm, ".rs1"}, rs1_data, e1);
            check({nm, ".rs2"}, rs2_data, e2);
        end
    endtask

    task automatic idle_write(input string nm, input logic [4:0] r, input logic [31:0] d);
        set_in(1'b1, r, d, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        cyc(nm, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic rd(input string nm, input logic [4:0] a, input logic [4:0] b,
                      input logic es, input logic ev, input logic [31:0] e1, input logic [31:0] e2);
        set_in(1'b0, 5'd0, 32'h0, 1'b1, a, b, 1'b0, 5'd0);
        cyc(nm, es, ev, e1, e2);
    endtask

    task automatic mark(input string nm, input logic [4:0] r, input logic es, input logic ev);
        set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 1'b1, r);
        cyc(nm, es, ev, 32'h0, 32'h0);
    endtask

    vec_t vt [11];

    initial begin
        logic        bp;
`ifdef WB_BYPASS_EN
        bp = 1'b1;
`else
        bp = 1'b0;
`endif
        //            we wrd   wdata         req rs1    rs2    mk mrd    stall valid d1            d2
        vt[0]  = mk(0, 5'd0,  32'h0,        1, 5'd0,  5'd5,  0, 5'd0,  0,    1,    32'h0,        32'h0);
        vt[1]  = mk(1, 5'd10, 32'hA5A5A5A5, 0, 5'd0,  5'd0,  0, 5'd0,  0,    0,    32'h0,        32'h0);
        vt[2]  = mk(0, 5'd0,  32'h0,        1, 5'd10, 5'd0,  0, 5'd0,  0,    1,    32'hA5A5A5A5, 32'h0);
        vt[3]  = mk(1, 5'd0,  32'hFFFFFFFF, 0, 5'd0,  5'd0,  0, 5'd0,  0,    0,    32'h0,        32'h0);
        vt[4]  = mk(0, 5'd0,  32'h0,        1, 5'd0,  5'd0,  0, 5'd0,  0,    1,    32'h0,        32'h0);
        // stray write to r5 read in the same cycle: forwarded only with bypass
        vt[5]  = mk(1, 5'd5,  32'h12345678, 1, 5'd5,  5'd10, 0, 5'd0,  0,    1,
                    bp ? 32'h12345678 : 32'h0, 32'hA5A5A5A5);
        vt[6]  = mk(0, 5'd0,  32'h0,        1, 5'd5,  5'd5,  0, 5'd0,  0,    1,    32'h12345678, 32'h12345678);
        vt[7]  = mk(0, 5'd0,  32'h0,        1, 5'd10, 5'd5,  1, 5'd7,  0,    1,    32'hA5A5A5A5, 32'h12345678);
        vt[8]  = mk(0, 5'd0,  32'h0,        1, 5'd0,  5'd7,  0, 5'd0,  1,    0,    32'h0,        32'h0);
        // last pending write to r7 lands while decode waits on it
        vt[9]  = mk(1, 5'd7,  32'h5A5A5A5A, 1, 5'd0,  5'd7,  0, 5'd0,  !bp,  bp,   32'h0,        32'h5A5A5A5A);
        vt[10] = mk(0, 5'd0,  32'h0,        1, 5'd7,  5'd7,  0, 5'd0,  0,    1,    32'h5A5A5A5A, 32'h5A5A5A5A);

        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset.valid", {31'b0, rd_valid}, 32'h0);
        check("reset.rs1", rs1_data, 32'h0);
        check("reset.rs2", rs2_data, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            set_in(vt[i].we, vt[i].wrd, vt[i].wdata, vt[i].req, vt[i].rs1, vt[i].rs2,
                   vt[i].mark, vt[i].mrd);
            cyc($sformatf("vec%0d", i), vt[i].stall, vt[i].valid, vt[i].d1, vt[i].d2);
        end

        // Saturation of r3: three marks accepted, fourth stalls
        mark("sat.m1", 5'd3, 1'b0, 1'b1);
        mark("sat.m2", 5'd3, 1'b0, 1'b1);
        mark("sat.m3", 5'd3, 1'b0, 1'b1);
        mark("sat.m4", 5'd3, 1'b1, 1'b0);
        rd("sat.busy", 5'd3, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0);
        idle_write("sat.w1", 5'd3, 32'h11);
        idle_write("sat.w2", 5'd3, 32'h22);
        rd("sat.busy1", 5'd0, 5'd3, 1'b1, 1'b0, 32'h0, 32'h0);
        idle_write("sat.w3", 5'd3, 32'h33);
        rd("sat.read", 5'd3, 5'd0, 1'b0, 1'b1, 32'h33, 32'h0);

        // Mark and write of r4 in the same cycle keep pend[4] at 1
        mark("r4.m1", 5'd4, 1'b0, 1'b1);
        set_in(1'b1, 5'd4, 32'h44, 1'b1, 5'd0, 5'd0, 1'b1, 5'd4);
        cyc("r4.mw", 1'b0, 1'b1, 32'h0, 32'h0);
        rd("r4.busy", 5'd4, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0);
        idle_write("r4.w", 5'd4, 32'h55);
        rd("r4.read", 5'd0, 5'd4, 1'b0, 1'b1, 32'h0, 32'h55);

        // Reset in the cycle after an accepted request (which also marked r9)
        set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 5'd0, 1'b1, 5'd9);
        cyc("rst.pre", 1'b0, 1'b1, 32'hA5A5A5A5, 32'h0);
        set_in(1'b1, 5'd10, 32'hDEADBEEF, 1'b1, 5'd10, 5'd9, 1'b0, 5'd0);
        reset = 1'b1;
        cyc("rst.cyc", 1'b1, 1'b0, 32'h0, 32'h0);
        check("rst.rs1", rs1_data, 32'h0);
        check("rst.rs2", rs2_data, 32'h0);
        reset = 1'b0;
        rd("rst.after", 5'd10, 5'd9, 1'b0, 1'b1, 32'h0, 32'h0);
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        cyc("rst.idle", 1'b0, 1'b0, 32'h0, 32'h0);
        check("hold.rs1", rs1_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
